// File: rtl/prio_mixer_pkg.sv
// prio_mixer_pkg: shared constants and types for the N-layer priority mixer.
//   - CPU register map offsets (ctrl, background, per-layer priority tables, layer enable)
//   - priority width, background layer index
//   - cand_t: one layer candidate as seen by the winner/runner-up ranker
package prio_mixer_pkg;

  localparam int unsigned PRIO_W        = 4;
  localparam int unsigned REG_CTRL      = 0;
  localparam int unsigned REG_BG        = 1;
  localparam int unsigned REG_PRIO_BASE = 2;

  localparam int unsigned CTRL_BLEND_BIT = 0;
  localparam int unsigned CTRL_LATCH_BIT = 1;

  localparam logic [2:0] LAYER_BG = 3'd7;

  // Layer-enable register sits right after the n two-byte priority tables.
  function automatic int unsigned reg_en(input int unsigned n);
    return REG_PRIO_BASE + 2 * n;
  endfunction

  typedef struct packed {
    logic              valid;
    logic [PRIO_W-1:0] prio;
    logic [2:0]        idx;
  } cand_t;

endpackage

// File: rtl/prio_rank.sv
// prio_rank: combinational winner / runner-up selector.
//   i_cand : NUM_LAYERS candidates {valid, prio, idx}
//   o_win  : highest-priority valid candidate (ties -> lowest index), valid=0 if none
//   o_run  : best valid candidate other than o_win, same rules, valid=0 if none
module prio_rank
  import prio_mixer_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 4
) (
  input  cand_t [NUM_LAYERS-1:0] i_cand,
  output cand_t                  o_win,
  output cand_t                  o_run
);

  cand_t w_win;
  cand_t w_run;

  // Strict '>' while scanning upward keeps the lower index on a tie.
  always_comb begin
    w_win = '0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (i_cand[i].valid && (!w_win.valid || (i_cand[i].prio > w_win.prio))) begin
        w_win = i_cand[i];
      end
    end
  end

  always_comb begin
    w_run = '0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (i_cand[i].valid && !(w_win.valid && (i_cand[i].idx == w_win.idx)) &&
          (!w_run.valid || (i_cand[i].prio > w_run.prio))) begin
        w_run = i_cand[i];
      end
    end
  end

  assign o_win = w_win;
  assign o_run = w_run;

endmodule

// File: rtl/prio_mixer.sv
// prio_mixer: N-layer priority mixer with CPU staging registers and optional
// vblank-latched active copy. Two ce_pixel stages from color_in to outputs.
//   clk, reset_n       : clock, asynchronous active-low reset
//   ce_pixel, vblank   : pixel enable, vertical blank level
//   cs, cpu_rw, cpu_addr, cpu_ds_n, cpu_din, cpu_dout : 8-bit CPU register port
//   color_in           : NUM_LAYERS packed colour words, layer i at [i*COLOR_W +: COLOR_W]
//   color_out, prio_out, layer_out : mixed colour, winning priority, winning layer (7 = bg)
module prio_mixer
  import prio_mixer_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned COLOR_W    = 14,
  parameter int unsigned PEN_W      = 4,
  parameter int unsigned ADDR_W     = 5
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ce_pixel,
  input  logic                          vblank,
  input  logic                          cs,
  input  logic                          cpu_rw,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic [1:0]                    cpu_ds_n,
  input  logic [7:0]                    cpu_din,
  output logic [7:0]                    cpu_dout,
  input  logic [NUM_LAYERS*COLOR_W-1:0] color_in,
  output logic [COLOR_W-1:0]            color_out,
  output logic [PRIO_W-1:0]             prio_out,
  output logic [2:0]                    layer_out
);

  localparam int unsigned NREG   = 2 * NUM_LAYERS + 3;
  localparam int unsigned REG_EN = reg_en(NUM_LAYERS);

  // ---------------------------------------------------------------------------
  // CPU staging registers and active copy
  // ---------------------------------------------------------------------------
  logic [7:0] r_stg [NREG];
  logic [7:0] r_act [NREG];
  logic [7:0] r_cpu_dout;
  logic       r_vbl_q;

  logic       w_wr_en;
  logic       w_rd_en;
  logic [7:0] w_rd_data;
  logic       w_latch;
  logic       w_vbl_rise;

  assign w_wr_en    = cs & ~cpu_rw & ~cpu_ds_n[0];
  assign w_rd_en    = cs & cpu_rw;
  assign w_latch    = r_act[REG_CTRL][CTRL_LATCH_BIT];
  assign w_vbl_rise = vblank & ~r_vbl_q;

  // Unmapped addresses read as all ones.
  always_comb begin
    w_rd_data = 8'hFF;
    for (int unsigned r = 0; r < NREG; r++) begin
      if (cpu_addr == ADDR_W'(r)) w_rd_data = r_stg[r];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned r = 0; r < NREG; r++) r_stg[r] <= '0;
      r_cpu_dout <= '0;
      r_vbl_q    <= 1'b0;
    end else begin
      if (w_wr_en) begin
        for (int unsigned r = 0; r < NREG; r++) begin
          if (cpu_addr == ADDR_W'(r)) r_stg[r] <= cpu_din;
        end
      end
      if (w_rd_en) r_cpu_dout <= w_rd_data;
      r_vbl_q <= vblank;
    end
  end

  // Ctrl always follows staging; the rest follows every clk unless latching, in
  // which case it copies only on a vblank rise. Same-edge CPU writes are missed
  // here because r_stg still holds its pre-write value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned r = 0; r < NREG; r++) r_act[r] <= '0;
    end else begin
      r_act[REG_CTRL] <= r_stg[REG_CTRL];
      if (!w_latch || w_vbl_rise) begin
        for (int unsigned r = 1; r < NREG; r++) r_act[r] <= r_stg[r];
      end
    end
  end

  assign cpu_dout = r_cpu_dout;

  // ---------------------------------------------------------------------------
  // Stage 1: per-layer opacity and priority lookup
  // ---------------------------------------------------------------------------
  logic [COLOR_W-1:0]    w_word [NUM_LAYERS];
  logic [PRIO_W-1:0]     w_prio [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] w_opq;

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
    logic [1:0]  w_sel;
    logic [15:0] w_tbl;
    assign w_word[g] = color_in[g*COLOR_W +: COLOR_W];
    assign w_sel     = w_word[g][COLOR_W-1 -: 2];
    assign w_tbl     = {r_act[REG_PRIO_BASE + 2*g + 1], r_act[REG_PRIO_BASE + 2*g]};
    assign w_prio[g] = w_tbl[{w_sel, 2'b00} +: PRIO_W];
    assign w_opq[g]  = r_act[REG_EN][g] & (|w_word[g][PEN_W-1:0]);
  end

  logic [NUM_LAYERS-1:0] r_s1_opq;
  logic [PRIO_W-1:0]     r_s1_prio [NUM_LAYERS];
  logic [COLOR_W-1:0]    r_s1_col  [NUM_LAYERS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_opq <= '0;
      for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
        r_s1_prio[i] <= '0;
        r_s1_col[i]  <= '0;
      end
    end else if (ce_pixel) begin
      r_s1_opq <= w_opq;
      for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
        r_s1_prio[i] <= w_prio[i];
        r_s1_col[i]  <= w_word[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: rank, optional pen blend, background fallback
  // ---------------------------------------------------------------------------
  cand_t [NUM_LAYERS-1:0] w_cand;
  cand_t                  w_win;
  cand_t                  w_run;

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_cand
    assign w_cand[g] = {r_s1_opq[g], r_s1_prio[g], 3'(g)};
  end

  prio_rank #(
    .NUM_LAYERS(NUM_LAYERS)
  ) u_rank (
    .i_cand(w_cand),
    .o_win (w_win),
    .o_run (w_run)
  );

  logic [COLOR_W-1:0] w_win_col;
  logic [PEN_W-1:0]   w_run_pen;
  logic               w_blend;
  logic [COLOR_W-1:0] w_col_d;
  logic [PRIO_W-1:0]  w_prio_d;
  logic [2:0]         w_layer_d;

  always_comb begin
    w_win_col = '0;
    w_run_pen = '0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (w_win.idx == 3'(i)) w_win_col = r_s1_col[i];
      if (w_run.idx == 3'(i)) w_run_pen = r_s1_col[i][PEN_W-1:0];
    end
  end

  // Blend only when the runner-up sits exactly one level below; prio 0 cannot wrap.
  assign w_blend = r_act[REG_CTRL][CTRL_BLEND_BIT] & w_run.valid & (w_win.prio != '0) &
                   (w_run.prio == (w_win.prio - PRIO_W'(1)));

  always_comb begin
    w_col_d   = {{(COLOR_W-8){1'b0}}, r_act[REG_BG]};
    w_prio_d  = '0;
    w_layer_d = LAYER_BG;
    if (w_win.valid) begin
      w_col_d   = w_blend ? {w_win_col[COLOR_W-1:PEN_W], w_run_pen} : w_win_col;
      w_prio_d  = w_win.prio;
      w_layer_d = w_win.idx;
    end
  end

  logic [COLOR_W-1:0] r_color;
  logic [PRIO_W-1:0]  r_prio;
  logic [2:0]         r_layer;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_color <= '0;
      r_prio  <= '0;
      r_layer <= LAYER_BG;
    end else if (ce_pixel) begin
      r_color <= w_col_d;
      r_prio  <= w_prio_d;
      r_layer <= w_layer_d;
    end
  end

  assign color_out = r_color;
  assign prio_out  = r_prio;
  assign layer_out = r_layer;

  logic w_unused;
  assign w_unused = ^{cpu_ds_n[1], r_act[REG_CTRL], r_act[REG_EN], w_run.idx};

endmodule

// File: tb/tb_prio_mixer.sv
// tb_prio_mixer: directed self-checking bench for prio_mixer (4 layers, 14-bit colour).
module tb_prio_mixer;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 14;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ce_pixel;
  logic          vblank;
  logic          cs;
  logic          cpu_rw;
  logic [AW-1:0] cpu_addr;
  logic [1:0]    cpu_ds_n;
  logic [7:0]    cpu_din;
  logic [7:0]    cpu_dout;
  logic [N*CW-1:0] color_in;
  logic [CW-1:0] color_out;
  logic [3:0]    prio_out;
  logic [2:0]    layer_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prio_mixer #(
    .NUM_LAYERS(N),
    .COLOR_W   (CW),
    .PEN_W     (4),
    .ADDR_W    (AW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ce_pixel (ce_pixel),
    .vblank   (vblank),
    .cs       (cs),
    .cpu_rw   (cpu_rw),
    .cpu_addr (cpu_addr),
    .cpu_ds_n (cpu_ds_n),
    .cpu_din  (cpu_din),
    .cpu_dout (cpu_dout),
    .color_in (color_in),
    .color_out(color_out),
    .prio_out (prio_out),
    .layer_out(layer_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [CW-1:0] c, input logic [3:0] p,
                            input logic [2:0] l);
    chk({tag, ".col"}, 16'(color_out), 16'(c));
    chk({tag, ".prio"}, 16'(prio_out), 16'(p));
    chk({tag, ".layer"}, 16'(layer_out), 16'(l));
  endtask

  // Write then idle one clk so the active copy (latch off) has caught up.
  task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
    cs = 1'b1; cpu_rw = 1'b0; cpu_ds_n = 2'b00; cpu_addr = a; cpu_din = d;
    tick();
    cs = 1'b0; cpu_rw = 1'b1; cpu_ds_n = 2'b11;
    tick();
  endtask

  task automatic rd(input string tag, input logic [AW-1:0] a, input logic [7:0] e);
    cs = 1'b1; cpu_rw = 1'b1; cpu_addr = a;
    tick();
    cs = 1'b0;
    chk(tag, {8'h00, cpu_dout}, {8'h00, e});
  endtask

  function automatic logic [N*CW-1:0] mk(input logic [CW-1:0] w0, input logic [CW-1:0] w1,
                                         input logic [CW-1:0] w2, input logic [CW-1:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic feed(input logic [N*CW-1:0] v);
    color_in = v; ce_pixel = 1'b1;
    tick();
    ce_pixel = 1'b0;
  endtask

  task automatic pix(input logic [N*CW-1:0] v);
    feed(v);
    feed(v);
  endtask

  logic [N*CW-1:0] all5;

  initial begin
    reset_n = 1'b0; ce_pixel = 1'b0; vblank = 1'b0; cs = 1'b0; cpu_rw = 1'b1;
    cpu_addr = '0; cpu_ds_n = 2'b11; cpu_din = '0; color_in = '0;
    all5 = mk(14'h0105, 14'h0205, 14'h0305, 14'h1405);
    #12;
    expect_out("reset", 14'h0000, 4'd0, 3'd7);
    chk("reset.dout", {8'h00, cpu_dout}, 16'h0000);
    reset_n = 1'b1;
    tick();

    // Enable all layers, tables L0..L3 = 0x1111..0x4444.
    wr(5'd10, 8'h0F);
    wr(5'd2, 8'h11); wr(5'd3, 8'h11);
    wr(5'd4, 8'h22); wr(5'd5, 8'h22);
    wr(5'd6, 8'h33); wr(5'd7, 8'h33);
    wr(5'd8, 8'h44); wr(5'd9, 8'h44);

    feed(all5);
    expect_out("lat1", 14'h0000, 4'd0, 3'd7);
    feed(all5);
    expect_out("all5", 14'h1405, 4'd4, 3'd3);

    color_in = '0;
    tick(); tick(); tick();
    expect_out("hold", 14'h1405, 4'd4, 3'd3);

    pix(mk(14'h0105, 14'h0205, 14'h0300, 14'h1400));
    expect_out("l1win", 14'h0205, 4'd2, 3'd1);

    wr(5'd1, 8'hA5);
    pix(mk(14'h0100, 14'h0200, 14'h0300, 14'h1400));
    expect_out("bg", 14'h00A5, 4'd0, 3'd7);

    // Tie between L0 and L2 at prio 3.
    wr(5'd2, 8'h33); wr(5'd3, 8'h33);
    pix(mk(14'h0105, 14'h0205, 14'h0305, 14'h1400));
    expect_out("tie", 14'h0105, 4'd3, 3'd0);

    // Blend: L1 prio 5 over L0 prio 4.
    wr(5'd0, 8'h01);
    wr(5'd4, 8'h50); wr(5'd5, 8'h00);
    wr(5'd2, 8'h04); wr(5'd3, 8'h00);
    pix(mk(14'h0009, 14'h1236, 14'h0300, 14'h1400));
    expect_out("blend", 14'h1239, 4'd5, 3'd1);
    wr(5'd2, 8'h03);
    pix(mk(14'h0009, 14'h1236, 14'h0300, 14'h1400));
    expect_out("noblend", 14'h1236, 4'd5, 3'd1);

    wr(5'd0, 8'h00);
    wr(5'd2, 8'h11); wr(5'd3, 8'h11);
    wr(5'd4, 8'h22); wr(5'd5, 8'h22);
    pix(all5);
    expect_out("restore", 14'h1405, 4'd4, 3'd3);

    // Vblank-latched updates.
    wr(5'd0, 8'h02);
    wr(5'd8, 8'h00); wr(5'd9, 8'h00);
    pix(all5);
    expect_out("vbl_pre", 14'h1405, 4'd4, 3'd3);
    vblank = 1'b1; tick(); tick();
    vblank = 1'b0; tick();
    pix(all5);
    expect_out("vbl_post", 14'h0305, 4'd3, 3'd2);

    // Write on the rise clk goes to staging only.
    cs = 1'b1; cpu_rw = 1'b0; cpu_ds_n = 2'b00; cpu_addr = 5'd8; cpu_din = 8'h44;
    vblank = 1'b1;
    tick();
    cs = 1'b0; cpu_rw = 1'b1; cpu_ds_n = 2'b11;
    tick();
    vblank = 1'b0; tick();
    pix(all5);
    expect_out("vbl_risewr", 14'h0305, 4'd3, 3'd2);
    rd("stg8", 5'd8, 8'h44);
    vblank = 1'b1; tick();
    vblank = 1'b0; tick();
    pix(all5);
    expect_out("vbl_next", 14'h1405, 4'd4, 3'd3);

    // CPU port corner cases.
    rd("rd_oob", 5'd31, 8'hFF);
    rd("rd_en", 5'd10, 8'h0F);
    cs = 1'b1; cpu_rw = 1'b0; cpu_ds_n = 2'b01; cpu_addr = 5'd1; cpu_din = 8'h3C;
    tick();
    cs = 1'b0; cpu_rw = 1'b1; cpu_ds_n = 2'b11;
    rd("ds_ign", 5'd1, 8'hA5);
    cpu_addr = 5'd31;
    tick(); tick();
    chk("dout_hold", {8'h00, cpu_dout}, 16'h00A5);

    // Reset mid-pipeline.
    feed(all5);
    reset_n = 1'b0;
    #1;
    expect_out("rst_mid", 14'h0000, 4'd0, 3'd7);
    chk("rst_dout", {8'h00, cpu_dout}, 16'h0000);
    #3;
    reset_n = 1'b1;
    tick();
    pix(all5);
    expect_out("post_rst", 14'h0000, 4'd0, 3'd7);
    rd("rst_en", 5'd10, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
